vga_timing: RTL and testbench
=============================

# vga_timing

Free-running XGA raster timing generator for the 65 MHz VGA domain. It produces registered horizontal/vertical pixel counters, blanking flags, sync pulses and frame/line-start strobes. All drawing stages (grid, ships, cursor) downstream consume this block's outputs in lock-step. Default geometry is 1024x768@60 Hz inside a 1344x806 total raster.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 1'b0, active level of hsync (0 = negative pulse)
- VS_POL, 1'b0, active level of vsync

Ports:
- vga_clk  in  1  pixel clock, 65 MHz; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- vcount  out  11  vertical position, 0..V_TOTAL-1
- hblnk  out  1  high when hcount >= H_ACTIVE
- vblnk  out  1  high when vcount >= V_ACTIVE
- hsync  out  1  equals HS_POL while hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL
- vsync  out  1  equals VS_POL while vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~VS_POL
- line_start  out  1  one-cycle strobe when hcount==0 (not asserted in reset)
- frame_start  out  1  one-cycle strobe when hcount==0 and vcount==0 (not asserted in reset)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Horizontal counter increments every cycle; at H_TOTAL-1 wraps to 0 and vertical counter advances.
- Vertical counter wraps from V_TOTAL-1 to 0 on the same edge that hcount wraps.
- Every output is a flip-flop; hblnk, vblnk, hsync, vsync, line_start and frame_start are computed from the next counter values so they are cycle-aligned with the hcount/vcount they describe (zero relative skew).
- No enable and no stall: counters run unconditionally while rst_n is high.
- Counter arithmetic is 11-bit unsigned; parameters must give H_TOTAL, V_TOTAL <= 2048 (elaboration-time check, $error otherwise).
- Default sync windows: hsync active for hcount 1048..1183, vsync active for vcount 771..776.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-line): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
- First rising edge after rst_n release: hcount=1, vcount=0. The first frame_start occurs at the first wrap to (0,0), 1344*806 = 1,083,264 cycles after release.
- Line period: 1344 cycles. Frame period: 1,083,264 cycles (16.66 ms at 65 MHz).
- hblnk rises on the edge where hcount becomes 1024 and falls when hcount becomes 0.
- vblnk rises with vcount becoming 768 at hcount=0 and falls at the (0,0) wrap.
- Simultaneous wrap: at (1343,805) the next edge gives (0,0) with line_start=1 and frame_start=1 in the same cycle.
- Reset asserted mid-frame returns all outputs to reset values immediately, without waiting for a clock edge. Counting restarts from (0,0) on the release edge sequence.

## Test plan
- Reset: hold rst_n=0 for 5 cycles, pulse rst_n low mid-line at hcount~500 -> all outputs take reset values asynchronously; first edge after release gives hcount=1.
- Horizontal sweep: check across one line -> hblnk=1 exactly for hcount 1024..1343; hsync=0 exactly for 1048..1183; hcount wraps 1343->0 with line_start=1 for one cycle.
- Vertical sweep: run one full frame -> vblnk=1 for vcount 768..805; vsync=0 for vcount 771..776, changing only at hcount 0; vcount wraps 805->0.
- Frame strobe: count cycles between consecutive frame_start pulses -> exactly 1,083,264; line_start pulse count per frame = 806.
- Polarity override: set HS_POL=1 and VS_POL=1 -> sync windows identical but pulses high; reset value of hsync/vsync = 0.
- Image capture: drive a downstream stage and dump frames to TIFF at 1344x806 triggered on vsync -> two consecutive negedges of vsync 1,083,264 cycles apart, visible area 1024x768 aligned at (0,0).

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator (default XGA 1024x768@60,
// 1344x806 total). Counters, blanking, sync and start strobes are all
// registered and derived from the same next-state counter values, so every
// output describes the hcount/vcount presented in the same cycle.
module vga_timing #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized copies of the raster landmarks so all compares are 11-bit unsigned.
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Geometry that does not fit the 11-bit counters is rejected at elaboration.
  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_geometry
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        hblnk_next;
  logic        vblnk_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        line_start_next;
  logic        frame_start_next;

  // Next raster position: h always advances, v advances (and both may wrap)
  // only on the last pixel of a line.
  always_comb begin
    h_next = hcount + 11'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = 11'd0;
      v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
    end
  end

  // Decode flags from the next position so they land together with it.
  always_comb begin
    hblnk_next       = (h_next >= H_ACT);
    vblnk_next       = (v_next >= V_ACT);
    hsync_next       = ((h_next >= HS_BEG) && (h_next <= HS_END)) ? HS_POL : ~HS_POL;
    vsync_next       = ((v_next >= VS_BEG) && (v_next <= VS_END)) ? VS_POL : ~VS_POL;
    line_start_next  = (h_next == 11'd0);
    frame_start_next = (h_next == 11'd0) && (v_next == 11'd0);
  end

  // Output registers; reset forces the idle raster state immediately.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= hblnk_next;
      vblnk       <= vblnk_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: randomized reset/run segments on a reduced raster, checked
// every cycle against a position model computed from cycles-since-release.
module tb_vga_timing;

  // Reduced geometry keeps whole frames short: 25 x 16 = 400 cycles/frame.
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 10, VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount, vcount, hcount_p, vcount_p;
  logic        hblnk, vblnk, hsync, vsync, line_start, frame_start;
  logic        hblnk_p, vblnk_p, hsync_p, vsync_p, line_start_p, frame_start_p;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;   // rising edges since reset release
  int last_fs;     // k at previous frame_start within this segment (-1 none)
  int ls_cnt;      // line_start pulses since previous frame_start

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .vga_clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .vga_clk(clk), .rst_n(rst_n), .hcount(hcount_p), .vcount(vcount_p),
    .hblnk(hblnk_p), .vblnk(vblnk_p), .hsync(hsync_p), .vsync(vsync_p),
    .line_start(line_start_p), .frame_start(frame_start_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Expected outputs from raster arithmetic on the elapsed-cycle count.
  task automatic check_all(input bit in_rst);
    int n, h, v;
    bit hwin, vwin, e_ls, e_fs;
    if (in_rst) begin
      n = 0; h = 0; v = 0; hwin = 0; vwin = 0; e_ls = 0; e_fs = 0;
    end else begin
      n = k % FRAME;
      h = n % HT;
      v = n / HT;
      hwin = (h >= HA + HF) && (h < HA + HF + HS);
      vwin = (v >= VA + VF) && (v < VA + VF + VS);
      e_ls = (h == 0);
      e_fs = (n == 0);
    end
    chk("hcount", int'(hcount), h);
    chk("vcount", int'(vcount), v);
    chk("hblnk", int'(hblnk), (!in_rst && h >= HA) ? 1 : 0);
    chk("vblnk", int'(vblnk), (!in_rst && v >= VA) ? 1 : 0);
    chk("hsync", int'(hsync), hwin ? 0 : 1);
    chk("vsync", int'(vsync), vwin ? 0 : 1);
    chk("line_start", int'(line_start), int'(e_ls));
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("hcount_p", int'(hcount_p), h);
    chk("vcount_p", int'(vcount_p), v);
    chk("hsync_p", int'(hsync_p), hwin ? 1 : 0);
    chk("vsync_p", int'(vsync_p), vwin ? 1 : 0);
  endtask

  // Run n clock cycles after release, checking each and measuring strobes.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all(1'b0);
      if (line_start) ls_cnt++;
      if (frame_start) begin
        if (last_fs >= 0) begin
          chk("frame_period", k - last_fs, FRAME);
          chk("lines_per_frame", ls_cnt, VT);
        end
        last_fs = k;
        ls_cnt  = 0;
      end
    end
  endtask

  // Hold reset for n cycles, checking outputs stay at reset values.
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all(1'b1);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    k       = 0;
    last_fs = -1;
    ls_cnt  = 0;
  endtask

  initial begin
    int run_len, rst_len;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all(1'b1);
    hold_reset(5);
    // First edge after release must give hcount=1; covered by run_cycles.
    run_len = 500;
    run_cycles(run_len);
    $display("seg 0: reset 5 cycles, ran %0d cycles", run_len);

    for (int s = 1; s <= 9; s++) begin
      // Assert reset asynchronously, mid-cycle after a rising edge.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_all(1'b1);
      rst_len = int'($urandom_range(1, 6));
      hold_reset(rst_len);
      run_len = (s == 5) ? 1000 : int'($urandom_range(1, 700));
      run_cycles(run_len);
      $display("seg %0d: reset %0d cycles, ran %0d cycles", s, rst_len, run_len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
